// File: rtl/mdu_alu.sv
// rtl/mdu_alu.sv - ALU plus iterative shift-add multiplier and restoring divider with HI/LO
// Divider hardware is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU complete with err.
module mdu_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ANDN  = 4'b0100;
  localparam logic [3:0] OP_ORN   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     opd, opd_nxt;
  logic                 neg_q, neg_q_nxt;
  logic [WIDTH-1:0]     y_nxt, hi_nxt, lo_nxt;
  logic                 done_nxt, err_nxt;

  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step, mul_prod;

`ifdef MDU_DIV_EN
  logic                 neg_r, neg_r_nxt;
  logic [WIDTH:0]       div_shift, div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     div_quo, div_rem;
`endif

  // Signed ops have op[0]=0; iterations run on magnitudes and the sign is fixed at the end.
  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
  assign busy      = (state != IDLE);

  // acc holds {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};
  assign mul_prod = neg_q ? -mul_step : mul_step;

`ifdef MDU_DIV_EN
  // acc holds {partial remainder, dividend bits shifting into quotient}
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
  assign div_quo   = neg_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
  assign div_rem   = neg_r ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    opd_nxt   = opd;
    neg_q_nxt = neg_q;
`ifdef MDU_DIV_EN
    neg_r_nxt = neg_r;
`endif
    y_nxt     = y;
    hi_nxt    = hi;
    lo_nxt    = lo;
    done_nxt  = 1'b0;
    err_nxt   = err;

    case (state)
      IDLE: begin
        if (start) begin
          done_nxt = 1'b1;
          err_nxt  = 1'b0;
          case (op)
            OP_AND:  y_nxt = a & b;
            OP_OR:   y_nxt = a | b;
            OP_ADD:  y_nxt = a + b;
            OP_ANDN: y_nxt = a & ~b;
            OP_ORN:  y_nxt = a | ~b;
            OP_SUB:  y_nxt = a - b;
            OP_SLT:  y_nxt = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: y_nxt = hi;
            OP_MFLO: y_nxt = lo;
            OP_MULT, OP_MULTU: begin
              state_nxt = MUL;
              done_nxt  = 1'b0;
              cnt_nxt   = '0;
              acc_nxt   = {{WIDTH{1'b0}}, mag_a};
              opd_nxt   = mag_b;
              neg_q_nxt = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                hi_nxt  = a;
                lo_nxt  = '1;
                y_nxt   = '1;
                err_nxt = 1'b1;
              end else begin
                state_nxt = DIV;
                done_nxt  = 1'b0;
                cnt_nxt   = '0;
                acc_nxt   = {{WIDTH{1'b0}}, mag_a};
                opd_nxt   = mag_b;
                neg_q_nxt = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r_nxt = is_signed & a[WIDTH-1];
              end
            end
`endif
            default: begin
              y_nxt   = '0;
              err_nxt = 1'b1;
            end
          endcase
        end
      end
      MUL: begin
        acc_nxt = mul_step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hi_nxt    = mul_prod[2*WIDTH-1:WIDTH];
          lo_nxt    = mul_prod[WIDTH-1:0];
          y_nxt     = mul_prod[WIDTH-1:0];
          err_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
      end
`ifdef MDU_DIV_EN
      DIV: begin
        acc_nxt = div_step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          hi_nxt    = div_rem;
          lo_nxt    = div_quo;
          y_nxt     = div_quo;
          err_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opd   <= '0;
      neg_q <= 1'b0;
`ifdef MDU_DIV_EN
      neg_r <= 1'b0;
`endif
      y     <= '0;
      zero  <= 1'b1;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      opd   <= opd_nxt;
      neg_q <= neg_q_nxt;
`ifdef MDU_DIV_EN
      neg_r <= neg_r_nxt;
`endif
      y     <= y_nxt;
      zero  <= (y_nxt == '0);
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// tb/tb_mdu_alu.sv - directed self-checking bench for mdu_alu (WIDTH=32)
// Divider expectations follow MDU_DIV_EN as seen by this compile.
module tb_mdu_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] y, hi, lo;
  logic         zero, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .y(y), .zero(zero), .hi(hi), .lo(lo), .busy(busy), .done(done), .err(err)
  );

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = z;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cnt, output bit ok);
    cycles = 0; busy_cnt = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (busy) busy_cnt++;
      if (done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++; if (y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL reset_y y=%h zero=%b required y=0 zero=1", y, zero); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo hi=%h lo=%h required 0/0", hi, lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b err=%b required 0/0/0", busy, done, err); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_add;
    issue(4'b0010, 32'd5, 32'd7);
    checks++; if (y !== 32'd12 || zero !== 1'b0) begin errors++; $display("FAIL add_y y=%h zero=%b required 0000000c/0", y, zero); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL add_done done=%b busy=%b err=%b required 1/0/0", done, busy, err); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_pulse done=%b busy=%b required 0/0", done, busy); end
  endtask

  task automatic test_logic;
    issue(4'b0110, 32'd9, 32'd9);
    checks++; if (y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL sub_zero y=%h zero=%b required 0/1", y, zero); end
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    checks++; if (y !== 32'd1) begin errors++; $display("FAIL slt y=%h required 00000001", y); end
    issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
    checks++; if (y !== 32'd0) begin errors++; $display("FAIL slt_false y=%h required 0", y); end
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (y !== 32'h0000_F000) begin errors++; $display("FAIL and y=%h required 0000f000", y); end
    issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
    checks++; if (y !== 32'h0000_00F0) begin errors++; $display("FAIL andn y=%h required 000000f0", y); end
    issue(4'b0101, 32'h0000_0000, 32'hFFFF_0000);
    checks++; if (y !== 32'h0000_FFFF) begin errors++; $display("FAIL orn y=%h required 0000ffff", y); end
    issue(4'b0011, 32'd3, 32'd4);
    checks++; if (y !== 32'h0 || err !== 1'b1 || done !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL unsupported y=%h err=%b done=%b zero=%b required 0/1/1/1", y, err, done, zero); end
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    checks++; if (y !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL add_wrap y=%h err=%b required 0/0", y, err); end
  endtask

  task automatic test_mult;
    int cyc, bcnt;
    bit ok;
    issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mult_accept busy=%b done=%b required 1/0", busy, done); end
    wait_done(cyc, bcnt, ok);
    checks++; if (!ok || cyc != 32 || bcnt != 31 || busy !== 1'b0) begin errors++; $display("FAIL mult_timing ok=%0d cycles=%0d busy_after_accept=%0d required 1/32/31", ok, cyc, bcnt); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB || y !== 32'hFFFF_FFEB || err !== 1'b0) begin errors++; $display("FAIL mult_result hi=%h lo=%h y=%h err=%b required ffffffff/ffffffeb/ffffffeb/0", hi, lo, y, err); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_single_done done=%b required 0", done); end
    issue(4'b1100, 32'd0, 32'd0);
    checks++; if (y !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mfhi y=%h hi=%h lo=%h required ffffffff/ffffffff/ffffffeb", y, hi, lo); end
  endtask

  task automatic test_div;
`ifdef MDU_DIV_EN
    int cyc, bcnt;
    bit ok;
    issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_accept busy=%b required 1", busy); end
    wait_done(cyc, bcnt, ok);
    checks++; if (!ok || cyc != 32) begin errors++; $display("FAIL div_timing ok=%0d cycles=%0d required 1/32", ok, cyc); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || y !== 32'hFFFF_FFFD || err !== 1'b0) begin errors++; $display("FAIL div_result lo=%h hi=%h y=%h err=%b required fffffffd/ffffffff/fffffffd/0", lo, hi, y, err); end
    issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bcnt, ok);
    checks++; if (!ok || lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_ovf ok=%0d lo=%h hi=%h required 1/80000000/0", ok, lo, hi); end
    issue(4'b1011, 32'd100, 32'd7);
    wait_done(cyc, bcnt, ok);
    checks++; if (!ok || lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu ok=%0d lo=%h hi=%h required 1/0000000e/00000002", ok, lo, hi); end
    issue(4'b1011, 32'd7, 32'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL divz_flags done=%b busy=%b err=%b required 1/0/1", done, busy, err); end
    checks++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF || y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_result hi=%h lo=%h y=%h required 00000007/ffffffff/ffffffff", hi, lo, y); end
`else
    issue(4'b1010, 32'd10, 32'd2);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1 || y !== 32'h0) begin errors++; $display("FAIL div_disabled done=%b busy=%b err=%b y=%h required 1/0/1/0", done, busy, err, y); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL div_disabled_hilo hi=%h lo=%h required ffffffff/ffffffeb", hi, lo); end
    issue(4'b1011, 32'd7, 32'd0);
    checks++; if (err !== 1'b1 || y !== 32'h0 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL divu_disabled err=%b y=%h hi=%h lo=%h required 1/0/ffffffff/ffffffeb", err, y, hi, lo); end
`endif
  endtask

  task automatic test_busy_ignore;
    int cyc, bcnt;
    bit ok;
    issue(4'b1001, 32'hFFFF_FFFF, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ignore_start busy=%b done=%b required 1/0", busy, done); end
    wait_done(cyc, bcnt, ok);
    checks++; if (!ok || cyc + 4 != 32) begin errors++; $display("FAIL ignore_timing ok=%0d cycles=%0d required 1/28", ok, cyc); end
    checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE || y !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result hi=%h lo=%h y=%h required 00000001/fffffffe/fffffffe", hi, lo, y); end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    bit ok;
    @(negedge clk);
    start = 1'b1; op = 4'b0010; a = 32'd100; b = 32'd23;
    @(posedge clk); #1;
    checks++; if (y !== 32'd123 || done !== 1'b1) begin errors++; $display("FAIL b2b_add y=%h done=%b required 0000007b/1", y, done); end
    op = 4'b0110; a = 32'd20; b = 32'd5;
    @(posedge clk); #1;
    checks++; if (y !== 32'd15 || done !== 1'b1) begin errors++; $display("FAIL b2b_sub y=%h done=%b required 0000000f/1", y, done); end
    op = 4'b0001; a = 32'h0F; b = 32'hF0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (y !== 32'hFF || done !== 1'b1) begin errors++; $display("FAIL b2b_or y=%h done=%b required 000000ff/1", y, done); end
    issue(4'b1000, 32'd6, 32'd7);
    wait_done(cyc, bcnt, ok);
    start = 1'b1; op = 4'b1100; a = 32'd0; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (!ok || y !== 32'h0 || zero !== 1'b1 || done !== 1'b1 || lo !== 32'd42) begin errors++; $display("FAIL b2b_after_mult ok=%0d y=%h zero=%b done=%b lo=%h required 1/0/1/1/0000002a", ok, y, zero, done, lo); end
  endtask

  task automatic test_reset_abort;
    int seen;
    issue(4'b1000, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL abort_state busy=%b done=%b hi=%h lo=%h y=%h zero=%b required 0/0/0/0/0/1", busy, done, hi, lo, y, zero); end
    repeat (10) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen != 0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_no_done activity=%0d hi=%h lo=%h required 0/0/0", seen, hi, lo); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 4'h0; a = '0; b = '0;
    test_reset;
    test_add;
    test_logic;
    test_mult;
    test_div;
    test_busy_ignore;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
